hypervisor_ctrl: RTL and testbench
==================================

# hypervisor_ctrl

Hypervisor trap and register controller for the 4510 CPU subsystem. It decodes the 64-byte hypervisor I/O window (0xD640–0xD67F) that the system bus decoder selects through `hyper_cs`. In user mode, a CPU write into the window raises a one-cycle hypervisor trap (`hyp`). In hypervisor mode, the window is a scratch register file, and a write to offset 0x3F pulses `load_user_reg` so the CPU restores user state and returns.

## Interface
Parameters:
- None. Window size is fixed at 64 registers, indexed by `hyper_addr[5:0]`.

Ports:
- `clk` in 1: single system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `hyper_cs` in 1: window select from the bus decoder, valid in the same cycle as `hyper_addr`.
- `hyper_addr` in 8: CPU next-cycle address bits [7:0]; only [5:0] are used.
- `hyper_io_data_i` in 8: CPU next-cycle write data.
- `cpu_write` in 1: CPU next-cycle write strobe.
- `ready` in 1: bus ready; a transfer happens only when `ready` = 1.
- `hyper_mode` in 1: 1 while the CPU executes in hypervisor mode.
- `hyper_data_o` out 8: registered read data.
- `hyp` out 1: hypervisor trap request, one-cycle pulse.
- `load_user_reg` out 1: hypervisor-exit pulse; the CPU reloads user registers.
- `user_mapper_reg` out 8: user mapper byte, equal to register 0x10, combinational from the register.

## Operation
- Internal state:
  - `regs[0:62]`, 8 bits each.
  - `trap_id`, 6 bits.
- Access qualifiers:
  - Write access: `hyper_cs & cpu_write & ready`.
  - Read access: `hyper_cs & !cpu_write & ready`.
- User-mode write (`hyper_mode` = 0):
  - `hyp` <= 1 for exactly one cycle.
  - `trap_id` <= `hyper_addr[5:0]`.
  - The register file is not modified.
- Hypervisor-mode write to offset 0x3F:
  - `load_user_reg` <= 1 for one cycle.
  - The written data is discarded.
- Hypervisor-mode write to offsets 0x00–0x3E: `regs[offset]` <= `hyper_io_data_i`.
- Read access, legal in either mode:
  - Offsets 0x00–0x3E: `hyper_data_o` <= `regs[offset]`.
  - Offset 0x3F: `hyper_data_o` <= {`hyper_mode`, 1'b0, `trap_id`}.
- Holding conditions:
  - When there is no read access, `hyper_data_o` holds its value.
  - With `hyper_cs` = 0, no state changes occur except pulse deassertion.
- `hyp` and `load_user_reg` default to 0 every cycle unless re-triggered. Back-to-back qualifying writes produce back-to-back pulses.
- `hyp` is never asserted while `hyper_mode` = 1. `load_user_reg` is never asserted while `hyper_mode` = 0.

## Timing
- Reset (`reset` = 0 at a clock edge):
  - All `regs`, `trap_id`, and `hyper_data_o` become 0x00.
  - `hyp` = 0 and `load_user_reg` = 0.
  - `user_mapper_reg` = 0x00.
  - Reset overrides any simultaneous access. A pulse in flight is cleared.
- Read latency is 1 clock:
  - Address and select are presented in cycle N with `ready` = 1.
  - Data is valid on `hyper_data_o` from edge N+1. This matches the synchronous memory read so the bus mux can select it one cycle later.
- Write latency:
  - Register update is visible on read or on `user_mapper_reg` from edge N+1.
  - `hyp` and `load_user_reg` are high for the single cycle after edge N+1.
- `ready` = 0: the cycle is ignored entirely; the CPU repeats the access with `ready` high.
- `hyper_mode` is sampled in the same cycle as the write. A mode change in that cycle uses the pre-edge value.

## Structure
- Shared package `hyper_pkg`:
  - `HYPER_WIN_BASE` = 20'h0D640.
  - `HYPER_EXIT_OFS` = 6'h3F.
  - `HYPER_MAPPER_OFS` = 6'h10.
  - `HYPER_NREGS` = 64.
- One sub-module, `hyper_regfile`: 63×8 synchronous-write register file with a registered read port and a combinational tap for offset 0x10.
- The trap and exit logic stays in the top module.

## Test plan
- Reset: hold `reset` = 0 for 3 clocks. Then:
  - all outputs are 0;
  - read of 0x05 after reset returns 0x00.
- User trap:
  - Stimulus: `hyper_mode` = 0, write 0xAA to 0xD645 with `ready` = 1.
  - Response: `hyp` is high for exactly 1 cycle; a later read of 0x3F returns 0x05; a read of 0x05 returns 0x00.
- Hypervisor register:
  - Stimulus: `hyper_mode` = 1, write 0x5C to 0x10.
  - Response: `user_mapper_reg` = 0x5C after 1 edge; read of 0x10 returns 0x5C one clock after the request; `hyp` stays 0.
- Exit:
  - Stimulus: `hyper_mode` = 1, write 0x00 to 0x3F.
  - Response: `load_user_reg` is a 1-cycle pulse; a read of 0x3F returns {1, 0, `trap_id`}.
- Ready stall:
  - Stimulus: write with `ready` toggling 1/0 every cycle.
  - Response: only cycles with `ready` = 1 take effect; no double pulse when the same write is presented across a `ready` = 0 cycle and then `ready` = 1.
- Deselect: writes with `hyper_cs` = 0, in both modes, cause no register change and no pulses.

Source files
------------

// File: rtl/hyper_pkg.sv
// rtl/hyper_pkg.sv - shared constants for the hypervisor I/O window
package hyper_pkg;

  localparam logic [19:0] HYPER_WIN_BASE   = 20'h0D640;
  localparam logic [5:0]  HYPER_EXIT_OFS   = 6'h3F;
  localparam logic [5:0]  HYPER_MAPPER_OFS = 6'h10;
  localparam int          HYPER_NREGS      = 64;

  // Status byte returned when the exit offset is read.
  function automatic logic [7:0] hyper_status(input logic mode, input logic [5:0] trap_id);
    return {mode, 1'b0, trap_id};
  endfunction

endpackage

// File: rtl/hyper_regfile.sv
// rtl/hyper_regfile.sv - 63x8 scratch register file with registered read and mapper tap
module hyper_regfile
  import hyper_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en_i,
  input  logic [5:0] wr_addr_i,
  input  logic [7:0] wr_data_i,
  input  logic       rd_en_i,
  input  logic [5:0] rd_addr_i,
  input  logic [7:0] status_i,
  output logic [7:0] rd_data_o,
  output logic [7:0] mapper_o
);

  logic [7:0] mem_q [0:HYPER_NREGS-2];
  logic [7:0] rd_data_q;
  logic [7:0] rd_data_d;

  // The exit offset has no storage; its read slot carries the status byte instead.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      if (rd_addr_i == HYPER_EXIT_OFS) rd_data_d = status_i;
      else                             rd_data_d = mem_q[rd_addr_i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < HYPER_NREGS - 1; i++) mem_q[i] <= 8'h00;
      rd_data_q <= 8'h00;
    end else begin
      if (wr_en_i && wr_addr_i != HYPER_EXIT_OFS) mem_q[wr_addr_i] <= wr_data_i;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign mapper_o  = mem_q[HYPER_MAPPER_OFS];

endmodule

// File: rtl/hypervisor_ctrl.sv
// rtl/hypervisor_ctrl.sv - hypervisor window decode: user-mode trap, exit pulse, scratch registers
module hypervisor_ctrl
  import hyper_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       hyper_cs,
  input  logic [7:0] hyper_addr,
  input  logic [7:0] hyper_io_data_i,
  input  logic       cpu_write,
  input  logic       ready,
  input  logic       hyper_mode,
  output logic [7:0] hyper_data_o,
  output logic       hyp,
  output logic       load_user_reg,
  output logic [7:0] user_mapper_reg
);

  logic [5:0] ofs;
  logic       wr_acc;
  logic       rd_acc;
  logic       hyp_q, hyp_d;
  logic       load_q, load_d;
  logic [5:0] trap_id_q, trap_id_d;
  logic       unused_addr_hi;

  assign ofs            = hyper_addr[5:0];
  assign unused_addr_hi = ^hyper_addr[7:6];
  assign wr_acc         = hyper_cs & cpu_write & ready;
  assign rd_acc         = hyper_cs & ~cpu_write & ready;

  // Pulses fall back to 0 every cycle; mode is the pre-edge value of this cycle.
  always_comb begin
    hyp_d     = 1'b0;
    load_d    = 1'b0;
    trap_id_d = trap_id_q;
    if (wr_acc) begin
      if (!hyper_mode) begin
        hyp_d     = 1'b1;
        trap_id_d = ofs;
      end else if (ofs == HYPER_EXIT_OFS) begin
        load_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hyp_q     <= 1'b0;
      load_q    <= 1'b0;
      trap_id_q <= 6'h00;
    end else begin
      hyp_q     <= hyp_d;
      load_q    <= load_d;
      trap_id_q <= trap_id_d;
    end
  end

  hyper_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_acc & hyper_mode),
    .wr_addr_i (ofs),
    .wr_data_i (hyper_io_data_i),
    .rd_en_i   (rd_acc),
    .rd_addr_i (ofs),
    .status_i  (hyper_status(hyper_mode, trap_id_q)),
    .rd_data_o (hyper_data_o),
    .mapper_o  (user_mapper_reg)
  );

  assign hyp           = hyp_q;
  assign load_user_reg = load_q;

endmodule

// File: tb/tb_hypervisor_ctrl.sv
// tb/tb_hypervisor_ctrl.sv - directed and randomized checks of hypervisor_ctrl against a window model
module tb_hypervisor_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       hyper_cs = 1'b0;
  logic [7:0] hyper_addr = 8'h00;
  logic [7:0] hyper_io_data_i = 8'h00;
  logic       cpu_write = 1'b0;
  logic       ready = 1'b0;
  logic       hyper_mode = 1'b0;
  logic [7:0] hyper_data_o;
  logic       hyp;
  logic       load_user_reg;
  logic [7:0] user_mapper_reg;

  int checks = 0;
  int failures = 0;

  // Reference model of the window: 64 byte slots (slot 63 unused), trap id, output byte, pulses.
  byte unsigned m_regs [64];
  int           m_trap;
  byte unsigned m_dout;
  bit           m_hyp, m_load;

  always #5 clk = ~clk;

  hypervisor_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .hyper_cs        (hyper_cs),
    .hyper_addr      (hyper_addr),
    .hyper_io_data_i (hyper_io_data_i),
    .cpu_write       (cpu_write),
    .ready           (ready),
    .hyper_mode      (hyper_mode),
    .hyper_data_o    (hyper_data_o),
    .hyp             (hyp),
    .load_user_reg   (load_user_reg),
    .user_mapper_reg (user_mapper_reg)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic model_cycle(input bit rst, input bit cs, input int addr, input int data,
                             input bit we, input bit rdy, input bit mode);
    int o;
    o = addr % 64;
    if (!rst) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      m_trap = 0; m_dout = 0; m_hyp = 0; m_load = 0;
      return;
    end
    m_hyp = 0;
    m_load = 0;
    if (cs && rdy) begin
      if (we) begin
        if (!mode) begin
          m_hyp = 1;
          m_trap = o;
        end else if (o == 63) m_load = 1;
        else m_regs[o] = data[7:0];
      end else begin
        if (o == 63) m_dout = (mode ? 8'h80 : 8'h00) + 8'(m_trap);
        else m_dout = m_regs[o];
      end
    end
  endtask

  // One bus cycle: drive at the falling edge, check everything 1 time unit after the rising edge.
  task automatic step(input string tag, input bit rst, input bit cs, input int addr, input int data,
                      input bit we, input bit rdy, input bit mode);
    @(negedge clk);
    reset = rst; hyper_cs = cs; hyper_addr = 8'(addr); hyper_io_data_i = 8'(data);
    cpu_write = we; ready = rdy; hyper_mode = mode;
    model_cycle(rst, cs, addr, data, we, rdy, mode);
    @(posedge clk);
    #1;
    chk({tag, ".hyp"},    {7'd0, hyp},           {7'd0, m_hyp});
    chk({tag, ".load"},   {7'd0, load_user_reg}, {7'd0, m_load});
    chk({tag, ".data"},   hyper_data_o,          m_dout);
    chk({tag, ".mapper"}, user_mapper_reg,       m_regs[16]);
  endtask

  task automatic idle(input string tag, input bit mode);
    step(tag, 1, 0, 0, 0, 0, 0, mode);
  endtask

  initial begin
    // Reset held 3 clocks while a write is being offered.
    for (int i = 0; i < 3; i++) step("reset", 0, 1, 8'h45, 8'hAA, 1, 1, 0);
    chk("reset.data_const", hyper_data_o, 8'h00);
    step("rd05_after_reset", 1, 1, 8'h05, 0, 0, 1, 0);
    chk("rd05_after_reset.val", hyper_data_o, 8'h00);

    // User-mode trap: write 0xAA to 0xD645.
    step("user_trap", 1, 1, 8'h45, 8'hAA, 1, 1, 0);
    chk("user_trap.pulse", {7'd0, hyp}, 8'h01);
    idle("user_trap_end", 0);
    chk("user_trap.one_cycle", {7'd0, hyp}, 8'h00);
    step("rd3f_user", 1, 1, 8'h7F, 0, 0, 1, 0);
    chk("rd3f_user.trap", hyper_data_o, 8'h05);
    step("rd05_user", 1, 1, 8'h45, 0, 0, 1, 0);
    chk("rd05_user.unchanged", hyper_data_o, 8'h00);

    // Hypervisor register write to the mapper slot.
    step("hv_wr10", 1, 1, 8'h50, 8'h5C, 1, 1, 1);
    chk("hv_wr10.mapper", user_mapper_reg, 8'h5C);
    step("hv_rd10", 1, 1, 8'h50, 0, 0, 1, 1);
    chk("hv_rd10.val", hyper_data_o, 8'h5C);

    // Exit.
    step("exit", 1, 1, 8'h7F, 8'h00, 1, 1, 1);
    chk("exit.pulse", {7'd0, load_user_reg}, 8'h01);
    idle("exit_end", 1);
    step("rd3f_hv", 1, 1, 8'h7F, 0, 0, 1, 1);
    chk("rd3f_hv.status", hyper_data_o, 8'h85);

    // Ready stall: same user write with ready 0 then 1 gives one pulse; toggled ready stream.
    step("stall_r0", 1, 1, 8'h4A, 8'h11, 1, 0, 0);
    step("stall_r1", 1, 1, 8'h4A, 8'h11, 1, 1, 0);
    idle("stall_end", 0);
    for (int i = 0; i < 8; i++) step("toggle_rdy", 1, 1, 8'h40 + i, 8'h30 + i, 1, i % 2 == 0, 1);
    for (int i = 0; i < 8; i++) step("toggle_rd", 1, 1, 8'h40 + i, 0, 0, 1, 1);

    // Deselect in both modes, including the exit offset.
    for (int i = 0; i < 4; i++) step("desel", 1, 0, (i < 2) ? 8'h7F : 8'h50, 8'hEE, 1, 1, i % 2 == 1);
    step("desel_rd10", 1, 1, 8'h10, 0, 0, 1, 1);

    // Back-to-back user writes.
    step("b2b_0", 1, 1, 8'h01, 8'h00, 1, 1, 0);
    step("b2b_1", 1, 1, 8'h02, 8'h00, 1, 1, 0);
    idle("b2b_end", 0);

    // Randomized traffic biased to the exit and mapper offsets, with occasional reset.
    for (int i = 0; i < 600; i++) begin
      int a, sel;
      sel = int'($urandom_range(0, 9));
      a = int'($urandom_range(0, 255));
      if (sel == 0) a = (a & 8'hC0) | 8'h3F;
      else if (sel == 1) a = (a & 8'hC0) | 8'h10;
      step("rand", $urandom_range(0, 99) != 0, $urandom_range(0, 4) != 0, a,
           int'($urandom_range(0, 255)), $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
